reset_seq_ctrl: RTL and testbench

Reset sequencer that produces the staged, block-level resets consumed by the per-block reset synchronizers. It merges a software reset pulse and a push-button reset into one reset request and stretches it to a guaranteed minimum assertion width. It then releases `NUM_STAGES` active-low reset outputs one at a time, in index order, with a fixed gap between stages. It sits at the top level between the chip reset source and the block reset inputs.

---
 rtl/reset_seq_pkg.sv | 23 ++
 rtl/reset_seq_ctrl_if.sv | 36 +++
 rtl/reset_seq_ctrl_btn_debounce.sv | 64 ++++++
 rtl/reset_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_reset_seq_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
// Contents: FSM state encoding, default parameter values, counter width helper.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_RELEASE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   localparam int unsigned DEF_NUM_STAGES      = 4;
   localparam int unsigned DEF_MIN_ASSERT      = 16;
   localparam int unsigned DEF_STAGE_GAP       = 8;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

   // Width of a counter that must hold values up to max(a, b).
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/reset_seq_ctrl_if.sv
// Request/status bundle between the reset source side and the sequencer.
//   SW_RST_REQ : software reset request, one-cycle pulse (to sequencer)
//   BTN_N      : asynchronous push-button, active-low (to sequencer)
//   RST_OUT_N  : staged active-low block resets (from sequencer)
//   RST_BUSY   : any stage still held in reset (from sequencer)
//   RST_DONE   : all stages released (from sequencer)
// master = reset source / observer side, slave = reset_seq_ctrl.
interface reset_seq_ctrl_if
   import reset_seq_pkg::*;
#(
   parameter int unsigned NUM_STAGES = DEF_NUM_STAGES
);

   logic                  SW_RST_REQ;
   logic                  BTN_N;
   logic [NUM_STAGES-1:0] RST_OUT_N;
   logic                  RST_BUSY;
   logic                  RST_DONE;

   modport master (
      output SW_RST_REQ,
      output BTN_N,
      input  RST_OUT_N,
      input  RST_BUSY,
      input  RST_DONE
   );

   modport slave (
      input  SW_RST_REQ,
      input  BTN_N,
      output RST_OUT_N,
      output RST_BUSY,
      output RST_DONE
   );

endinterface

// File: rtl/reset_seq_ctrl_btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, optionally followed by a
// stable-level debounce filter (compile-time macro RESET_SEQ_DEBOUNCE_EN).
//   CLOCK   : system clock
//   RESET   : async active-low reset
//   btn_n   : raw asynchronous button, active-low
//   pressed : registered conditioned pressed level (1 = pressed)
// Latency from button edge to pressed: 2 edges, or 2+DEBOUNCE_CYCLES with
// the filter compiled in.
module btn_debounce
   import reset_seq_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic CLOCK,
   input  logic RESET,
   input  logic btn_n,
   output logic pressed
);

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("btn_debounce: DEBOUNCE_CYCLES must be >= 1");
   end

   logic btn_meta;
   logic btn_sync;

   // Synchronizer stores the pressed polarity so the idle value is 0.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         btn_meta <= 1'b0;
         btn_sync <= 1'b0;
      end else begin
         btn_meta <= ~btn_n;
         btn_sync <= btn_meta;
      end
   end

`ifdef RESET_SEQ_DEBOUNCE_EN
   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [DB_W-1:0] db_cnt;

   // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         db_cnt  <= '0;
         pressed <= 1'b0;
      end else if (btn_sync != pressed) begin
         if (db_cnt == DB_LAST) begin
            pressed <= btn_sync;
            db_cnt  <= '0;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end else begin
         db_cnt <= '0;
      end
   end
`else
   assign pressed = btn_sync;
`endif

endmodule

// File: rtl/reset_seq_ctrl.sv
// Staged reset sequencer. Merges a software pulse and a push-button into one
// request, holds all block resets low for at least MIN_ASSERT edges, then
// releases RST_OUT_N[0..NUM_STAGES-1] in order, STAGE_GAP edges apart.
//   CLOCK : system clock (rising edge)
//   RESET : async active-low reset
//   bus   : reset_seq_ctrl_if.slave (SW_RST_REQ, BTN_N in; RST_OUT_N,
//           RST_BUSY, RST_DONE out, all outputs registered)
// Optional button debounce: define RESET_SEQ_DEBOUNCE_EN.
module reset_seq_ctrl
   import reset_seq_pkg::*;
#(
   parameter int unsigned NUM_STAGES      = DEF_NUM_STAGES,
   parameter int unsigned MIN_ASSERT      = DEF_MIN_ASSERT,
   parameter int unsigned STAGE_GAP       = DEF_STAGE_GAP,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic            CLOCK,
   input  logic            RESET,
   reset_seq_ctrl_if.slave bus
);

   localparam int unsigned CNT_W = cnt_width(MIN_ASSERT, STAGE_GAP);
   localparam int unsigned STG_W = $clog2(NUM_STAGES + 1);

   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(MIN_ASSERT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
   localparam logic [STG_W-1:0] STAGE_LAST  = STG_W'(NUM_STAGES - 1);

   if (NUM_STAGES < 1 || NUM_STAGES > 16) begin : g_bad_stages
      $error("reset_seq_ctrl: NUM_STAGES must be in 1..16");
   end
   if (MIN_ASSERT < 1) begin : g_bad_assert
      $error("reset_seq_ctrl: MIN_ASSERT must be >= 1");
   end
   if (STAGE_GAP < 1) begin : g_bad_gap
      $error("reset_seq_ctrl: STAGE_GAP must be >= 1");
   end

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [STG_W-1:0]      stage_q, stage_d;
   logic [NUM_STAGES-1:0] out_q, out_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  btn_pressed;
   logic                  req_c;
   logic [CNT_W-1:0]      cnt_inc_c;

   // Button conditioning (synchronizer + optional debounce).
   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .CLOCK   (CLOCK),
      .RESET   (RESET),
      .btn_n   (bus.BTN_N),
      .pressed (btn_pressed)
   );

   // A held button is a continuous request.
   assign req_c = bus.SW_RST_REQ | btn_pressed;

   // Saturating increment; the counter never wraps.
   assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   // State, counters and output registers.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state_q <= ST_ASSERT;
         cnt_q   <= '0;
         stage_q <= '0;
         out_q   <= '0;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state and next-output logic; a request overrides every state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stage_d = stage_q;
      out_d   = out_q;
      busy_d  = busy_q;
      done_d  = done_q;

      if (req_c) begin
         state_d = ST_ASSERT;
         cnt_d   = '0;
         stage_d = '0;
         out_d   = '0;
         busy_d  = 1'b1;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               if (cnt_q == ASSERT_LAST) begin
                  cnt_d    = '0;
                  out_d[0] = 1'b1;
                  stage_d  = STG_W'(1);
                  if (NUM_STAGES == 1) begin
                     state_d = ST_DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_RELEASE;
                  end
               end else begin
                  cnt_d = cnt_inc_c;
               end
            end

            ST_RELEASE: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_d   = '0;
                  stage_d = stage_q + STG_W'(1);
                  for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                     if (stage_q == STG_W'(i)) begin
                        out_d[i] = 1'b1;
                     end
                  end
                  if (stage_q == STAGE_LAST) begin
                     state_d = ST_DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_inc_c;
               end
            end

            ST_DONE: begin
               out_d  = '1;
               busy_d = 1'b0;
               done_d = 1'b1;
            end

            default: begin
               state_d = ST_ASSERT;
               cnt_d   = '0;
               stage_d = '0;
               out_d   = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
            end
         endcase
      end
   end

   assign bus.RST_OUT_N = out_q;
   assign bus.RST_BUSY  = busy_q;
   assign bus.RST_DONE  = done_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl with default parameters. Edge numbers
// count rising edges after RESET release (edge 1 = first edge with RESET=1).
// Button timing adapts to RESET_SEQ_DEBOUNCE_EN when defined.
module tb_reset_seq_ctrl;
   import reset_seq_pkg::*;

   localparam int unsigned NS = 4;
   localparam int unsigned MA = 16;
   localparam int unsigned SG = 8;
   localparam int unsigned DC = 4;
`ifdef RESET_SEQ_DEBOUNCE_EN
   localparam int BTN_LAT = 2 + DC;
`else
   localparam int BTN_LAT = 2;
`endif

   logic CLOCK = 1'b0;
   logic RESET = 1'b1;

   reset_seq_ctrl_if #(.NUM_STAGES(NS)) bus ();

   reset_seq_ctrl #(
      .NUM_STAGES      (NS),
      .MIN_ASSERT      (MA),
      .STAGE_GAP       (SG),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct {
      int         edge_n;
      logic       sw;
      logic [3:0] out;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t tbl [0:26];
   int   checks = 0;
   int   errors = 0;
   int   edge_n = 0;

   task automatic chk(input string nm, input logic [3:0] o, input logic b, input logic d);
      checks++;
      if (bus.RST_OUT_N !== o) begin
         errors++;
         $display("FAIL %s edge %0d: RST_OUT_N got %b want %b", nm, edge_n, bus.RST_OUT_N, o);
      end
      checks++;
      if (bus.RST_BUSY !== b) begin
         errors++;
         $display("FAIL %s edge %0d: RST_BUSY got %b want %b", nm, edge_n, bus.RST_BUSY, b);
      end
      checks++;
      if (bus.RST_DONE !== d) begin
         errors++;
         $display("FAIL %s edge %0d: RST_DONE got %b want %b", nm, edge_n, bus.RST_DONE, d);
      end
   endtask

   task automatic step();
      @(posedge CLOCK);
      edge_n++;
      #1;
   endtask

   task automatic goto(input int e);
      while (edge_n < e) step();
   endtask

   task automatic power_on();
      RESET = 1'b0;
      bus.SW_RST_REQ = 1'b0;
      bus.BTN_N = 1'b1;
      step();
      step();
      step();
      chk("reset_vals", 4'b0000, 1'b1, 1'b0);
      RESET = 1'b1;
      edge_n = 0;
   endtask

   task automatic run_tbl(input int lo, input int hi, input string nm);
      for (int i = lo; i <= hi; i++) begin
         goto(tbl[i].edge_n - 1);
         bus.SW_RST_REQ = tbl[i].sw;
         step();
         bus.SW_RST_REQ = 1'b0;
         chk(nm, tbl[i].out, tbl[i].busy, tbl[i].done);
      end
   endtask

   function automatic vec_t mk(input int e, input logic s, input logic [3:0] o,
                               input logic b, input logic d);
      vec_t v;
      v.edge_n = e;
      v.sw     = s;
      v.out    = o;
      v.busy   = b;
      v.done   = d;
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int e0;

      // Power-up release timing, then a software request from ST_DONE.
      tbl[0]  = mk(1,   1'b0, 4'b0000, 1'b1, 1'b0);
      tbl[1]  = mk(15,  1'b0, 4'b0000, 1'b1, 1'b0);
      tbl[2]  = mk(16,  1'b0, 4'b0001, 1'b1, 1'b0);
      tbl[3]  = mk(23,  1'b0, 4'b0001, 1'b1, 1'b0);
      tbl[4]  = mk(24,  1'b0, 4'b0011, 1'b1, 1'b0);
      tbl[5]  = mk(31,  1'b0, 4'b0011, 1'b1, 1'b0);
      tbl[6]  = mk(32,  1'b0, 4'b0111, 1'b1, 1'b0);
      tbl[7]  = mk(39,  1'b0, 4'b0111, 1'b1, 1'b0);
      tbl[8]  = mk(40,  1'b0, 4'b1111, 1'b0, 1'b1);
      tbl[9]  = mk(60,  1'b0, 4'b1111, 1'b0, 1'b1);
      tbl[10] = mk(100, 1'b1, 4'b0000, 1'b1, 1'b0);
      tbl[11] = mk(115, 1'b0, 4'b0000, 1'b1, 1'b0);
      tbl[12] = mk(116, 1'b0, 4'b0001, 1'b1, 1'b0);
      tbl[13] = mk(139, 1'b0, 4'b0111, 1'b1, 1'b0);
      tbl[14] = mk(140, 1'b0, 4'b1111, 1'b0, 1'b1);
      // Software request mid-release.
      tbl[15] = mk(27,  1'b0, 4'b0011, 1'b1, 1'b0);
      tbl[16] = mk(28,  1'b1, 4'b0000, 1'b1, 1'b0);
      tbl[17] = mk(43,  1'b0, 4'b0000, 1'b1, 1'b0);
      tbl[18] = mk(44,  1'b0, 4'b0001, 1'b1, 1'b0);
      tbl[19] = mk(52,  1'b0, 4'b0011, 1'b1, 1'b0);
      tbl[20] = mk(68,  1'b0, 4'b1111, 1'b0, 1'b1);
      // Repeated requests during assert extend the assertion.
      tbl[21] = mk(10,  1'b1, 4'b0000, 1'b1, 1'b0);
      tbl[22] = mk(16,  1'b0, 4'b0000, 1'b1, 1'b0);
      tbl[23] = mk(20,  1'b1, 4'b0000, 1'b1, 1'b0);
      tbl[24] = mk(35,  1'b0, 4'b0000, 1'b1, 1'b0);
      tbl[25] = mk(36,  1'b0, 4'b0001, 1'b1, 1'b0);
      tbl[26] = mk(60,  1'b0, 4'b1111, 1'b0, 1'b1);

      bus.SW_RST_REQ = 1'b0;
      bus.BTN_N = 1'b1;
      #2;

      power_on();
      run_tbl(0, 14, "powerup_sw_done");

      power_on();
      run_tbl(15, 20, "sw_mid_release");

      power_on();
      run_tbl(21, 26, "sw_repeat_assert");

      // Asynchronous reset mid-sequence, then power-up timing repeats.
      power_on();
      goto(30);
      chk("pre_async", 4'b0011, 1'b1, 1'b0);
      RESET = 1'b0;
      #1;
      chk("async_immediate", 4'b0000, 1'b1, 1'b0);
      step();
      chk("async_held", 4'b0000, 1'b1, 1'b0);
      RESET = 1'b1;
      edge_n = 0;
      run_tbl(0, 8, "after_async");

      // Button path from ST_DONE.
      goto(45);
      chk("btn_idle", 4'b1111, 1'b0, 1'b1);
`ifdef RESET_SEQ_DEBOUNCE_EN
      bus.BTN_N = 1'b0;
      step();
      step();
      step();
      bus.BTN_N = 1'b1;
      goto(edge_n + 10);
      chk("btn_glitch", 4'b1111, 1'b0, 1'b1);
`endif
      e0 = edge_n;
      bus.BTN_N = 1'b0;
      goto(e0 + BTN_LAT);
      chk("btn_press_before", 4'b1111, 1'b0, 1'b1);
      step();
      chk("btn_press_after", 4'b0000, 1'b1, 1'b0);
      goto(e0 + 30);
      chk("btn_held", 4'b0000, 1'b1, 1'b0);
      bus.BTN_N = 1'b1;
      goto(e0 + 30 + BTN_LAT + 16 - 1);
      chk("btn_rel_before", 4'b0000, 1'b1, 1'b0);
      step();
      chk("btn_rel_bit0", 4'b0001, 1'b1, 1'b0);
      goto(e0 + 30 + BTN_LAT + 16 + 24);
      chk("btn_rel_done", 4'b1111, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
